// File: rtl/camo_key_loader.sv
// Serial key loader for the locked c432 netlist: receives key+fold checksum LSB first,
// applies the key only after the checksum verifies, and locks out after repeated failures.
module camo_key_loader #(
  parameter int KEY_W    = 12,
  parameter int CHK_W    = 4,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic [3:0]       fail_cnt,
  output logic             locked_out
);

  localparam int SR_W  = KEY_W + CHK_W;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT_C = CNT_W'(SR_W - 1);
  localparam logic [3:0]       MAX_FAIL_C = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ARMED   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [SR_W-1:0]   sreg_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [KEY_W-1:0]  key_r;
  logic              key_valid_r;
  logic              err_r;
  logic [3:0]        fail_cnt_r;
  logic              locked_out_r;

  logic [KEY_W-1:0]  rx_key_s;
  logic [CHK_W-1:0]  rx_chk_s;
  logic              pass_s;
  logic [3:0]        fail_inc_s;

  // XOR-fold of the key into CHK_W-bit lanes: chk[i] = ^key[i + j*CHK_W]
  function automatic logic [CHK_W-1:0] fold_chk(input logic [KEY_W-1:0] k);
    logic [CHK_W-1:0] acc;
    acc = '0;
    for (int j = 0; j < KEY_W / CHK_W; j++) begin
      acc = acc ^ k[j*CHK_W +: CHK_W];
    end
    return acc;
  endfunction

  assign rx_key_s   = sreg_r[KEY_W-1:0];
  assign rx_chk_s   = sreg_r[SR_W-1:KEY_W];
  assign pass_s     = (fold_chk(rx_key_s) == rx_chk_s);
  assign fail_inc_s = (fail_cnt_r >= MAX_FAIL_C) ? MAX_FAIL_C : (fail_cnt_r + 4'd1);

  assign bit_ready  = (state_r == ST_SHIFT);
  assign busy       = (state_r == ST_SHIFT) || (state_r == ST_CHECK);
  assign key        = key_r;
  assign key_valid  = key_valid_r;
  assign err        = err_r;
  assign fail_cnt   = fail_cnt_r;
  assign locked_out = locked_out_r;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_SHIFT;
        else       state_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (abort)                                state_s = ST_IDLE;
        else if (bit_valid && cnt_r == LAST_BIT_C) state_s = ST_CHECK;
        else                                      state_s = ST_SHIFT;
      end
      ST_CHECK: begin
        if (pass_s)                         state_s = ST_ARMED;
        else if (fail_inc_s == MAX_FAIL_C)  state_s = ST_LOCKOUT;
        else                                state_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (start) state_s = ST_SHIFT;
        else       state_s = ST_ARMED;
      end
      ST_LOCKOUT: state_s = ST_LOCKOUT;
      default:    state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Datapath and registered outputs; the key register only ever loads verified data
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_r       <= '0;
      cnt_r        <= '0;
      key_r        <= '0;
      key_valid_r  <= 1'b0;
      err_r        <= 1'b0;
      fail_cnt_r   <= 4'd0;
      locked_out_r <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sreg_r <= '0;
          cnt_r  <= '0;
        end
        ST_SHIFT: begin
          if (abort) begin
            sreg_r <= '0;
            cnt_r  <= '0;
          end else if (bit_valid) begin
            sreg_r <= {bit_in, sreg_r[SR_W-1:1]};
            cnt_r  <= cnt_r + CNT_W'(1);
          end else begin
            sreg_r <= sreg_r;
          end
        end
        ST_CHECK: begin
          sreg_r <= '0;
          cnt_r  <= '0;
          if (pass_s) begin
            key_r       <= rx_key_s;
            key_valid_r <= 1'b1;
            fail_cnt_r  <= 4'd0;
          end else begin
            key_r        <= '0;
            key_valid_r  <= 1'b0;
            err_r        <= 1'b1;
            fail_cnt_r   <= fail_inc_s;
            locked_out_r <= (fail_inc_s == MAX_FAIL_C);
          end
        end
        ST_ARMED: begin
          // Zeroize on reload so the old key is never visible during a new load
          if (start) begin
            key_r       <= '0;
            key_valid_r <= 1'b0;
          end else begin
            key_r <= key_r;
          end
        end
        ST_LOCKOUT: begin
          sreg_r       <= '0;
          cnt_r        <= '0;
          key_r        <= '0;
          key_valid_r  <= 1'b0;
          locked_out_r <= 1'b1;
        end
        default: begin
          sreg_r      <= '0;
          cnt_r       <= '0;
          key_r       <= '0;
          key_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camo_key_loader.sv
// Self-checking bench for camo_key_loader: directed vector table, hand-written corner
// sequences, and randomized loads checked against a transaction-level model.
module tb_camo_key_loader;

  localparam int MAXF = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort, bit_in, bit_valid;
  logic        bit_ready, key_valid, busy, err, locked_out;
  logic [11:0] key;
  logic [3:0]  fail_cnt;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  logic [11:0] m_key;
  logic        m_valid;
  logic [3:0]  m_fail;
  logic        m_lock;

  typedef struct {
    logic [15:0] stream;
    int          stalls;
    logic [11:0] exp_key;
    logic        exp_valid;
    logic [3:0]  exp_fail;
    logic        exp_err;
    logic        exp_lock;
  } vec_t;

  vec_t vecs[8];

  camo_key_loader #(.KEY_W(12), .CHK_W(4), .MAX_FAIL(MAXF)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .key(key), .key_valid(key_valid),
    .busy(busy), .err(err), .fail_cnt(fail_cnt), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] fold(input logic [11:0] k);
    int v;
    v = int'(k);
    return 4'((v ^ (v >> 4) ^ (v >> 8)) & 15);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".key"}, 32'(key), 32'd0);
    chk({tag, ".key_valid"}, 32'(key_valid), 32'd0);
    chk({tag, ".bit_ready"}, 32'(bit_ready), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
    chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'd0);
    chk({tag, ".locked_out"}, 32'(locked_out), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_key = 12'd0; m_valid = 1'b0; m_fail = 4'd0; m_lock = 1'b0;
  endtask

  // Model: outcome of one complete 16-bit load given the current model state
  task automatic model_next(input logic [15:0] s, output logic [11:0] k, output logic v,
                            output logic [3:0] f, output logic e, output logic l);
    if (m_lock) begin
      k = 12'd0; v = 1'b0; f = m_fail; e = 1'b0; l = 1'b1;
    end else if (fold(s[11:0]) == s[15:12]) begin
      k = s[11:0]; v = 1'b1; f = 4'd0; e = 1'b0; l = 1'b0;
    end else begin
      k = 12'd0; v = 1'b0;
      f = (m_fail >= 4'(MAXF)) ? 4'(MAXF) : m_fail + 4'd1;
      e = 1'b1; l = (f == 4'(MAXF));
    end
  endtask

  // One full load: start, 16 bits (optional stall before bit stall_at), then verify
  task automatic load(input string tag, input logic [15:0] s, input int stalls, input int stall_at,
                      input logic [11:0] ek, input logic ev, input logic [3:0] ef,
                      input logic ee, input logic el);
    logic rdy_exp;
    rdy_exp = !m_lock;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".zeroize_key"}, 32'(key), 32'd0);
    chk({tag, ".zeroize_valid"}, 32'(key_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        bit_valid = 1'b0;
        for (int n = 0; n < stalls; n++) begin
          tick();
          chk({tag, ".stall_ready"}, 32'(bit_ready), 32'(rdy_exp));
        end
      end
      bit_valid = 1'b1;
      bit_in    = s[i];
      chk({tag, ".bit_ready"}, 32'(bit_ready), 32'(rdy_exp));
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    chk({tag, ".chk_busy"}, 32'(busy), 32'(rdy_exp));
    chk({tag, ".chk_key_valid"}, 32'(key_valid), 32'd0);
    tick();
    chk({tag, ".key"}, 32'(key), 32'(ek));
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(ev));
    chk({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(ef));
    chk({tag, ".err"}, 32'(err), 32'(ee));
    chk({tag, ".locked_out"}, 32'(locked_out), 32'(el));
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    tick();
    chk({tag, ".err_one_cycle"}, 32'(err), 32'd0);
    chk({tag, ".key_hold"}, 32'(key), 32'(ek));
    m_key = ek; m_valid = ev; m_fail = ef; m_lock = el;
  endtask

  initial begin
    logic [11:0] k;
    logic        v, e, l;
    logic [3:0]  f;
    logic [15:0] s;
    logic [15:0] g;

    rst = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    m_key = 12'd0; m_valid = 1'b0; m_fail = 4'd0; m_lock = 1'b0;

    vecs[0] = '{16'h3A5C, 0, 12'hA5C, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[1] = '{16'h4A5C, 2, 12'h000, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[2] = '{16'h3A5C, 0, 12'hA5C, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[3] = '{16'hF0F0, 1, 12'h0F0, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[4] = '{16'h4A5C, 0, 12'h000, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[5] = '{16'h4A5C, 3, 12'h000, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[6] = '{16'h4A5C, 0, 12'h000, 1'b0, 4'd3, 1'b1, 1'b1};
    vecs[7] = '{16'h3A5C, 0, 12'h000, 1'b0, 4'd3, 1'b0, 1'b1};

    tick(); tick();
    rst = 1'b0;
    check_zero("reset");

    for (int i = 0; i < 8; i++) begin
      load($sformatf("vec%0d", i), vecs[i].stream, vecs[i].stalls, 8, vecs[i].exp_key,
           vecs[i].exp_valid, vecs[i].exp_fail, vecs[i].exp_err, vecs[i].exp_lock);
    end
    chk("lockout_hold", 32'(locked_out), 32'd1);
    do_reset();
    check_zero("rst_from_lockout");

    // Stall for 5 cycles mid-stream, then abort with a valid bit after bit 9
    start = 1'b1; tick(); start = 1'b0;
    g = 16'h3A5C;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        bit_valid = 1'b0;
        for (int n = 0; n < 5; n++) begin
          tick();
          chk("stall5_ready", 32'(bit_ready), 32'd1);
          chk("stall5_busy", 32'(busy), 32'd1);
        end
      end
      bit_valid = 1'b1; bit_in = g[i];
      tick();
    end
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    chk("abort_ready", 32'(bit_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fail_cnt", 32'(fail_cnt), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    load("after_abort", 16'h3A5C, 0, 0, 12'hA5C, 1'b1, 4'd0, 1'b0, 1'b0);
    load("reload", 16'hF0F0, 0, 0, 12'h0F0, 1'b1, 4'd0, 1'b0, 1'b0);

    // Reset after bit 7 of a load
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1; bit_in = g[i];
      tick();
    end
    bit_valid = 1'b0;
    do_reset();
    check_zero("rst_midload");
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("rst_idle_ready", 32'(bit_ready), 32'd0);
    end

    // Randomized loads against the model
    for (int t = 0; t < 40; t++) begin
      k = 12'($urandom);
      if ($urandom_range(0, 1) == 0) s = {fold(k), k};
      else                            s = {fold(k) ^ 4'($urandom_range(1, 15)), k};
      model_next(s, k, v, f, e, l);
      load($sformatf("rnd%0d", t), s, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           k, v, f, e, l);
      if (m_lock && $urandom_range(0, 1) == 0) begin
        do_reset();
        check_zero("rnd_rst");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
